// File: rtl/pulse_rate_limiter_if.sv
// Handshake bundle between a pulse source and the rate limiter front end.
interface pulse_rate_limiter_if #(
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 pulse_in;
  logic                 ovf_clear;
  logic                 pulse_out;
  logic [CNT_WIDTH-1:0] pending;
  logic                 busy;
  logic                 overflow;

  modport master (
    output pulse_in, ovf_clear,
    input  pulse_out, pending, busy, overflow
  );

  modport slave (
    input  pulse_in, ovf_clear,
    output pulse_out, pending, busy, overflow
  );
endinterface

// File: rtl/pulse_rate_limiter.sv
// Counts input pulse events and re-issues them as 1-cycle pulses spaced MIN_GAP idle
// cycles apart, so a closed-loop CDC pulse synchronizer never sees one while busy.
module pulse_rate_limiter #(
  parameter int unsigned MIN_GAP   = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_rate_limiter_if.slave  bus
);

  localparam int unsigned GW = $clog2(MIN_GAP + 1);
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [GW-1:0]        GAP_LOAD = GW'(MIN_GAP);
  localparam logic [GW-1:0]        GAP_LAST = GW'(1);

  typedef enum logic [1:0] {IDLE, FIRE, GAP} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] pending_q, pending_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 ovf_q, ovf_d;
  logic                 inc, dec, drop, want;

  always_comb begin
    dec  = (state_q == FIRE);
    // At full with a FIRE in progress the new event replaces the issued one.
    drop = bus.pulse_in && (pending_q == PEND_MAX) && !dec;
    inc  = bus.pulse_in && !drop;
    want = (pending_q != '0) || bus.pulse_in;

    pending_d = pending_q + {{(CNT_WIDTH-1){1'b0}}, inc} - {{(CNT_WIDTH-1){1'b0}}, dec};
    ovf_d     = drop ? 1'b1 : (bus.ovf_clear ? 1'b0 : ovf_q);

    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: if (want) state_d = FIRE;
      FIRE: begin
        gap_d   = GAP_LOAD;
        state_d = GAP;
      end
      GAP: begin
        gap_d = gap_q - GAP_LAST;
        if (gap_q == GAP_LAST) state_d = want ? FIRE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      gap_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gap_q     <= gap_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.pulse_out = (state_q == FIRE);
  assign bus.pending   = pending_q;
  assign bus.busy      = (state_q != IDLE) || (pending_q != '0);
  assign bus.overflow  = ovf_q;

endmodule
